// File: rtl/cmp_pkg.sv
// Shared definitions for the multi-mode sequential comparator: mode codes,
// FSM state encoding and small mode-decoding helpers.
package cmp_pkg;

  localparam logic [2:0] CMP_EQ  = 3'd0;
  localparam logic [2:0] CMP_NE  = 3'd1;
  localparam logic [2:0] CMP_LTU = 3'd2;
  localparam logic [2:0] CMP_GEU = 3'd3;
  localparam logic [2:0] CMP_LTS = 3'd4;
  localparam logic [2:0] CMP_GES = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_signed(input logic [2:0] mode);
    return (mode == CMP_LTS) || (mode == CMP_GES);
  endfunction

  // Reserved codes (6, 7) always report false.
  function automatic logic mode_result(input logic [2:0] mode,
                                       input logic       zero,
                                       input logic       lt);
    logic res;
    case (mode)
      CMP_EQ:           res = zero;
      CMP_NE:           res = !zero;
      CMP_LTU, CMP_LTS: res = lt;
      CMP_GEU, CMP_GES: res = !lt;
      default:          res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational CHUNK-wide compare; msb_signed flips the top bit of both
// operands so an unsigned compare yields the two's-complement ordering.
module cmp_chunk #(
  parameter int CHUNK = 5
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             msb_signed,
  output logic             eq,
  output logic             lt
);

  logic [CHUNK-1:0] flip;
  logic [CHUNK-1:0] a_m;
  logic [CHUNK-1:0] b_m;

  always_comb begin
    flip            = '0;
    flip[CHUNK-1]   = msb_signed;
    a_m             = a ^ flip;
    b_m             = b ^ flip;
    eq              = (a_m == b_m);
    lt              = (a_m < b_m);
  end

endmodule

// File: rtl/cmp_unit.sv
// Sequential MSB-chunk-first comparator with valid/ready handshakes.
// Build option: CMP_EARLY_EXIT_EN ends the scan at the first differing chunk.
module cmp_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int CHUNK = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] register_A,
  input  logic [WIDTH-1:0] register_B,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic             zero_flag,
  output logic             lt_flag
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
    $error("cmp_unit: WIDTH must be a positive multiple of CHUNK");
  end

  state_t          state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [2:0]      mode_reg;
  logic [IDXW-1:0] idx_reg;
  logic            diff_seen_reg, lt_reg;
  logic            result_reg, zero_flag_reg, lt_flag_reg;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             msb_signed, chunk_eq, chunk_lt, chunk_diff;
  logic             diff_now, lt_now, scan_last;

  assign a_chunk    = a_reg[int'(idx_reg)*CHUNK +: CHUNK];
  assign b_chunk    = b_reg[int'(idx_reg)*CHUNK +: CHUNK];
  assign msb_signed = is_signed(mode_reg) && (idx_reg == LAST_IDX);

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a          (a_chunk),
    .b          (b_chunk),
    .msb_signed (msb_signed),
    .eq         (chunk_eq),
    .lt         (chunk_lt)
  );

  // Only the most significant differing chunk decides the ordering.
  assign chunk_diff = !chunk_eq;
  assign diff_now   = diff_seen_reg | chunk_diff;
  assign lt_now     = diff_seen_reg ? lt_reg : (chunk_diff & chunk_lt);
  assign scan_last  = (idx_reg == '0) || (EARLY_EXIT && chunk_diff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = SCAN;
      SCAN:    if (scan_last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      mode_reg      <= CMP_EQ;
      idx_reg       <= '0;
      diff_seen_reg <= 1'b0;
      lt_reg        <= 1'b0;
      result_reg    <= 1'b0;
      zero_flag_reg <= 1'b0;
      lt_flag_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          a_reg         <= register_A;
          b_reg         <= register_B;
          mode_reg      <= mode;
          idx_reg       <= LAST_IDX;
          diff_seen_reg <= 1'b0;
          lt_reg        <= 1'b0;
        end
        SCAN: begin
          diff_seen_reg <= diff_now;
          lt_reg        <= lt_now;
          if (scan_last) begin
            zero_flag_reg <= !diff_now;
            lt_flag_reg   <= lt_now;
            result_reg    <= mode_result(mode_reg, !diff_now, lt_now);
          end else begin
            idx_reg <= idx_reg - IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = result_reg;
  assign zero_flag = zero_flag_reg;
  assign lt_flag   = lt_flag_reg;

endmodule

// File: tb/tb_cmp_unit.sv
// Directed, table-driven bench for cmp_unit plus hand-written sequences for
// backpressure and mid-scan reset; latency expectations follow CMP_EARLY_EXIT_EN.
module tb_cmp_unit;
  import cmp_pkg::*;

  localparam int WIDTH  = 20;
  localparam int CHUNK  = 5;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int NVEC   = 14;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] register_A = '0;
  logic [WIDTH-1:0] register_B = '0;
  logic [2:0]       mode = 3'd0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             result, zero_flag, lt_flag;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       m;
    logic             r;
    logic             z;
    logic             l;
  } vec_t;

  vec_t vecs [NVEC];

  cmp_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .register_A (register_A),
    .register_B (register_B),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero_flag  (zero_flag),
    .lt_flag    (lt_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int exp_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef CMP_EARLY_EXIT_EN
    for (int i = NCHUNK - 1; i >= 0; i--)
      if (a[i*CHUNK +: CHUNK] != b[i*CHUNK +: CHUNK]) return NCHUNK - i;
`endif
    return NCHUNK;
  endfunction

  // Accept on the next rising edge, then scramble the inputs to prove capture.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] m);
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1);
    register_A = a;
    register_B = b;
    mode       = m;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    register_A = ~a;
    register_B = ~b;
    mode       = m ^ 3'd1;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("out_valid_within_budget", out_valid, 1);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_drops", out_valid, 0);
    check("in_ready_after_release", in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] m, input logic r, input logic z, input logic l);
    int lat;
    start_op(a, b, m);
    wait_done(lat);
    $display("%s: A=%h B=%h mode=%0d -> result=%0b zero=%0b lt=%0b latency=%0d",
             tag, a, b, m, result, zero_flag, lt_flag, lat);
    check({tag, "_result"}, result, r);
    check({tag, "_zero_flag"}, zero_flag, z);
    check({tag, "_lt_flag"}, lt_flag, l);
    check({tag, "_latency"}, lat, exp_latency(a, b));
    release_out();
  endtask

  initial begin
    int lat;
    vecs[0]  = '{20'hABCDE, 20'hABCDE, CMP_EQ,  1'b1, 1'b1, 1'b0};
    vecs[1]  = '{20'hABCDE, 20'hABCDF, CMP_NE,  1'b1, 1'b0, 1'b1};
    vecs[2]  = '{20'h80000, 20'h00001, CMP_LTS, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{20'h80000, 20'h00001, CMP_LTU, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{20'h80000, 20'h00001, CMP_GES, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{20'h80000, 20'h00001, CMP_GEU, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{20'h00001, 20'h00002, 3'd7,    1'b0, 1'b0, 1'b1};
    vecs[7]  = '{20'h80000, 20'h00001, 3'd6,    1'b0, 1'b0, 1'b0};
    vecs[8]  = '{20'h00001, 20'h00002, CMP_EQ,  1'b0, 1'b0, 1'b1};
    vecs[9]  = '{20'h00000, 20'h00000, CMP_NE,  1'b0, 1'b1, 1'b0};
    vecs[10] = '{20'hFFFFF, 20'h00000, CMP_LTS, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{20'hFFFFF, 20'h00000, CMP_GEU, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{20'h0001F, 20'h00020, CMP_LTU, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{20'h7FFFF, 20'h80000, CMP_GES, 1'b1, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_zero_flag", zero_flag, 0);
    check("reset_lt_flag", lt_flag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", in_ready, 1);

    for (int i = 0; i < NVEC; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].r, vecs[i].z, vecs[i].l);

    // Backpressure: hold the result for 5 cycles while offering a new operation.
    start_op(20'h12345, 20'h12345, CMP_EQ);
    wait_done(lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      register_A = 20'h00000;
      register_B = 20'h00001;
      mode       = CMP_LTU;
      in_valid   = 1'b1;
      check("hold_out_valid", out_valid, 1);
      check("hold_result", result, 1);
      check("hold_zero_flag", zero_flag, 1);
      check("hold_lt_flag", lt_flag, 0);
      check("hold_in_ready", in_ready, 0);
      $display("hold cycle %0d: out_valid=%0b result=%0b zero=%0b lt=%0b in_ready=%0b",
               c, out_valid, result, zero_flag, lt_flag, in_ready);
    end
    in_valid = 1'b0;
    release_out();
    run_op("after_hold", 20'h00003, 20'h00005, CMP_LTU, 1'b1, 1'b0, 1'b1);

    // Reset during the second SCAN cycle discards the pending result.
    start_op(20'h00001, 20'h00000, CMP_GEU);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midscan_reset_out_valid", out_valid, 0);
    check("midscan_reset_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("post_reset_no_result", out_valid, 0);
    end
    check("post_reset_in_ready", in_ready, 1);
    $display("mid-scan reset: out_valid=%0b in_ready=%0b", out_valid, in_ready);
    run_op("after_reset", 20'h00000, 20'h00000, CMP_GEU, 1'b1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
